jk_bank_sequencer: RTL and testbench

- Command-driven controller that sequences a WIDTH-bit bank of master-slave JK flip-flops.
- Accepts one command at a time over a valid/ready handshake.
- For each bit, every cycle, it generates the J/K pair that moves the bank from its current value (q_fb) to the value the command requires.
- Supports clear, set, load, masked toggle, multi-step count-up and multi-step serial shift.
- Sits between the register-control logic and the JK bank; the bank samples j/k on posedge clk.

---
 rtl/jk_bank_sequencer_if.sv | 32 +++
 rtl/jk_bank_sequencer.sv | 133 +++++++++++++
 tb/tb_jk_bank_sequencer.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/jk_bank_sequencer_if.sv
// Command and bank-facing signal bundle of the JK bank sequencer.
// master = command source plus bank side; slave = the sequencer itself.
interface jk_bank_sequencer_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
);
  // Handshake: a command transfers on a posedge where cmd_valid and cmd_ready are
  // both high. The source holds op/data/cnt stable while cmd_valid is high and
  // cmd_ready is low; cmd_ready never depends on cmd_valid.
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic [CNT_W-1:0] cmd_cnt;
  logic             sin;
  logic [WIDTH-1:0] q_fb;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    output cmd_valid, cmd_op, cmd_data, cmd_cnt, sin, q_fb,
    input  cmd_ready, j, k, busy, done, err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, cmd_cnt, sin, q_fb,
    output cmd_ready, j, k, busy, done, err
  );
endinterface

// File: rtl/jk_bank_sequencer.sv
// Command-driven sequencer producing per-bit J/K drive for an external JK bank.
// Each EXEC cycle recomputes the target from live q_fb, so bank disturbances are absorbed.
module jk_bank_sequencer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  jk_bank_sequencer_if.slave  bus,
  output logic [1:0]          dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [2:0] OP_NOP    = 3'b000;
  localparam logic [2:0] OP_CLEAR  = 3'b001;
  localparam logic [2:0] OP_SET    = 3'b010;
  localparam logic [2:0] OP_LOAD   = 3'b011;
  localparam logic [2:0] OP_TOGGLE = 3'b100;
  localparam logic [2:0] OP_COUNT  = 3'b101;
  localparam logic [2:0] OP_SHIFT  = 3'b110;
  localparam logic [2:0] OP_RSVD   = 3'b111;

  state_t           state_q, state_d;
  logic [2:0]       op_q,    op_d;
  logic [WIDTH-1:0] data_q,  data_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             err_q,   err_d;

  logic [WIDTH-1:0] shift_t;
  logic [WIDTH-1:0] tgt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= OP_NOP;
      data_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          op_d   = bus.cmd_op;
          data_d = bus.cmd_data;
          cnt_d  = bus.cmd_cnt;
          err_d  = 1'b0;
          case (bus.cmd_op)
            OP_CLEAR, OP_SET, OP_LOAD, OP_TOGGLE: begin
              cnt_d   = CNT_W'(1);
              state_d = S_EXEC;
            end
            OP_COUNT, OP_SHIFT: begin
              // A zero step count completes without touching the bank.
              state_d = (bus.cmd_cnt != '0) ? S_EXEC : S_DONE;
            end
            OP_RSVD: begin
              err_d   = 1'b1;
              state_d = S_DONE;
            end
            default: state_d = S_DONE;
          endcase
        end
      end
      S_EXEC: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  generate
    if (WIDTH == 1) begin : g_shift_narrow
      assign shift_t = bus.sin;
    end else begin : g_shift_wide
      assign shift_t = {bus.q_fb[WIDTH-2:0], bus.sin};
    end
  endgenerate

  always_comb begin
    tgt = bus.q_fb;
    case (op_q)
      OP_CLEAR: tgt = '0;
      OP_SET:   tgt = '1;
      OP_LOAD:  tgt = data_q;
      OP_COUNT: tgt = bus.q_fb + WIDTH'(1);
      OP_SHIFT: tgt = shift_t;
      default:  tgt = bus.q_fb;
    endcase
  end

  // Only TOGGLE may drive jk=11; every other op uses set/reset encoding.
  always_comb begin
    bus.j = '0;
    bus.k = '0;
    if (state_q == S_EXEC) begin
      if (op_q == OP_TOGGLE) begin
        bus.j = data_q;
        bus.k = data_q;
      end else begin
        bus.j = tgt & ~bus.q_fb;
        bus.k = ~tgt & bus.q_fb;
      end
    end
  end

  assign bus.cmd_ready = (state_q == S_IDLE);
  assign bus.busy      = (state_q == S_EXEC) || (state_q == S_DONE);
  assign bus.done      = (state_q == S_DONE);
  assign bus.err       = (state_q == S_DONE) && err_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_jk_bank_sequencer.sv
// Bench for jk_bank_sequencer: behavioural JK bank plus command-level reference model.
module tb_jk_bank_sequencer;
  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  jk_bank_sequencer_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();
  logic [1:0] dbg_state;

  jk_bank_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // Behavioural JK bank, independent of the sequencer reset.
  logic [WIDTH-1:0] bank;
  logic [WIDTH-1:0] bank_val;
  logic             bank_load;
  assign bus.q_fb = bank;
  always @(posedge clk) begin
    if (bank_load) bank <= bank_val;
    else           bank <= (bank & ~bus.k) | (~bank & bus.j);
  end

  int n_checks = 0;
  int n_fail   = 0;
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] exp_bank;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  function automatic int steps_of(input logic [2:0] op, input logic [CNT_W-1:0] cnt);
    case (op)
      3'd1, 3'd2, 3'd3, 3'd4: return 1;
      3'd5, 3'd6:             return int'(cnt);
      default:                return 0;
    endcase
  endfunction

  function automatic logic [WIDTH-1:0] model_next(input logic [2:0] op, input logic [WIDTH-1:0] data,
                                                   input logic [WIDTH-1:0] q, input logic s);
    case (op)
      3'd1:    return '0;
      3'd2:    return '1;
      3'd3:    return data;
      3'd4:    return q ^ data;
      3'd5:    return WIDTH'((int'(q) + 1) % (1 << WIDTH));
      3'd6:    return WIDTH'((int'(q) * 2 + int'(s)) % (1 << WIDTH));
      default: return q;
    endcase
  endfunction

  task automatic check_idle(input string tag);
    chk({tag, "_ready"}, 32'(bus.cmd_ready), 32'd1);
    chk({tag, "_busy"},  32'(bus.busy), 32'd0);
    chk({tag, "_done"},  32'(bus.done), 32'd0);
    chk({tag, "_err"},   32'(bus.err), 32'd0);
    chk({tag, "_jk"},    32'({bus.j, bus.k}), 32'd0);
  endtask

  task automatic preset(input logic [WIDTH-1:0] v);
    bank_load = 1'b1;
    bank_val  = v;
    @(posedge clk); #1;
    bank_load = 1'b0;
    @(negedge clk); #1;
    exp_bank = v;
    chk("preset_bank", 32'(bank), 32'(v));
  endtask

  // Called just after a negedge while the DUT is idle; returns likewise.
  // abort_step > 0 pulses rst in that step's cycle instead of checking it.
  task automatic run_cmd(input logic [2:0] op, input logic [WIDTH-1:0] data,
                         input logic [CNT_W-1:0] cnt, input logic [15:0] sin_bits,
                         input int abort_step);
    int n;
    logic [WIDTH-1:0] q, nxt, ej, ek;
    n = steps_of(op, cnt);
    q = exp_bank;
    exp_q.delete();
    exp_q.push_back(q);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_data  = data;
    bus.cmd_cnt   = cnt;
    @(posedge clk); #1;
    // Garbage while not ready must be ignored.
    bus.cmd_op   = 3'($urandom_range(0, 7));
    bus.cmd_data = WIDTH'($urandom);
    bus.cmd_cnt  = CNT_W'($urandom);
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      bus.sin = sin_bits[i-1];
      if (i == abort_step) begin
        rst = 1'b1;
        bus.cmd_valid = 1'b0;
        #1;
        check_idle("abort");
        chk("abort_bank", 32'(bank), 32'(exp_q.pop_front()));
        @(posedge clk); #1;
        chk("abort_hold", 32'(bank), 32'(q));
        @(negedge clk);
        rst = 1'b0;
        #1;
        exp_bank = q;
        check_idle("post_abort");
        return;
      end
      #1;
      chk("step_bank",  32'(bank), 32'(exp_q.pop_front()));
      chk("step_busy",  32'(bus.busy), 32'd1);
      chk("step_ready", 32'(bus.cmd_ready), 32'd0);
      chk("step_done",  32'(bus.done), 32'd0);
      nxt = model_next(op, data, q, bus.sin);
      if (op == 3'd4) begin
        ej = data;
        ek = data;
      end else begin
        ej = nxt & ~q;
        ek = ~nxt & q;
      end
      chk("step_j", 32'(bus.j), 32'(ej));
      chk("step_k", 32'(bus.k), 32'(ek));
      exp_q.push_back(nxt);
      q = nxt;
    end
    @(negedge clk); #1;
    chk("done_pulse", 32'(bus.done), 32'd1);
    chk("done_err",   32'(bus.err), 32'(op == 3'd7));
    chk("done_busy",  32'(bus.busy), 32'd1);
    chk("done_ready", 32'(bus.cmd_ready), 32'd0);
    chk("done_jk",    32'({bus.j, bus.k}), 32'd0);
    chk("done_bank",  32'(bank), 32'(exp_q.pop_front()));
    bus.cmd_valid = 1'b0;
    exp_bank = q;
    @(negedge clk); #1;
    check_idle("after_done");
    chk("idle_bank", 32'(bank), 32'(exp_bank));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 3'd0;
    bus.cmd_data  = '0;
    bus.cmd_cnt   = '0;
    bus.sin       = 1'b0;
    bank_load     = 1'b1;
    bank_val      = 8'h5A;
    exp_bank      = 8'h5A;

    @(negedge clk); @(negedge clk); #1;
    bank_load = 1'b0;
    check_idle("reset");
    chk("reset_bank", 32'(bank), 32'h5A);
    @(negedge clk);
    rst = 1'b0;
    #1;

    // Directed: CLEAR from 0x5A gives j=00, k=5A.
    run_cmd(3'd1, 8'h00, 4'd0, 16'h0, 0);
    chk("clear_result", 32'(bank), 32'h00);
    preset(8'h0F);
    run_cmd(3'd3, 8'hC3, 4'd0, 16'h0, 0);
    chk("load_result", 32'(bank), 32'hC3);
    preset(8'h80);
    run_cmd(3'd4, 8'h81, 4'd0, 16'h0, 0);
    chk("toggle_result", 32'(bank), 32'h01);
    preset(8'hFE);
    run_cmd(3'd5, 8'h00, 4'd3, 16'h0, 0);
    chk("count_wrap_result", 32'(bank), 32'h01);
    preset(8'h00);
    run_cmd(3'd6, 8'h00, 4'd4, 16'b1101, 0);
    chk("shift_result", 32'(bank), 32'h0B);
    run_cmd(3'd2, 8'h00, 4'd0, 16'h0, 0);
    chk("set_result", 32'(bank), 32'hFF);
    run_cmd(3'd7, 8'h55, 4'd5, 16'h0, 0);
    chk("rsvd_result", 32'(bank), 32'hFF);
    run_cmd(3'd5, 8'h00, 4'd0, 16'h0, 0);
    chk("count0_result", 32'(bank), 32'hFF);
    run_cmd(3'd0, 8'hAA, 4'd3, 16'h0, 0);
    preset(8'h10);
    run_cmd(3'd5, 8'h00, 4'd8, 16'h0, 4);
    chk("abort_result", 32'(bank), 32'h13);

    // Randomized commands against the model.
    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 3) == 0) preset(WIDTH'($urandom));
      run_cmd(3'($urandom_range(0, 7)), WIDTH'($urandom), CNT_W'($urandom_range(0, 15)),
              16'($urandom), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
